// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling, one-cycle
// valid / frame_err strobes, and lock-out of a stuck-low line after a framing error.
module uart_rx_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned H     = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t           state_q, state_d;
  logic             rxd_meta_q, rxd_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sr_q, sr_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // Synchronizer flops reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rxd_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          sr_d  = {rxd_s_q, sr_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            data_d  = sr_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rxd_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: table of back-to-back frames plus hand-written
// sequences for glitch, framing error, mid-frame reset and an odd bit period.
module tb_uart_rx_8n1;

  localparam int unsigned CPB  = 16;
  localparam int unsigned CPB2 = 5;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, rxd, rxd2;
  logic [7:0] data, data2;
  logic       valid, valid2, ferr, ferr2, busy, busy2;

  int unsigned n_checks = 0, n_fail = 0;
  int unsigned cyc = 0;
  int unsigned vcnt = 0, fcnt = 0, vcyc = 0, fcyc = 0;
  int unsigned vcnt2 = 0, fcnt2 = 0, vcyc2 = 0;
  logic [7:0]  vdata = 8'h00, vdata2 = 8'h00;

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .data(data), .valid(valid), .frame_err(ferr), .busy(busy)
  );

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB2)) dut5 (
    .clk(clk), .rst(rst), .rxd(rxd2),
    .data(data2), .valid(valid2), .frame_err(ferr2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe monitor: counts each high cycle, so a stretched strobe shows as an extra count.
  always @(negedge clk) begin
    if (valid || ferr) chk("strobe_exclusive", 32'(valid & ferr), 0);
    if (valid) begin vcnt++; vdata = data; vcyc = cyc; end
    if (ferr)  begin fcnt++; fcyc = cyc; end
    if (valid2 || ferr2) chk("strobe_exclusive_5", 32'(valid2 & ferr2), 0);
    if (valid2) begin vcnt2++; vdata2 = data2; vcyc2 = cyc; end
    if (ferr2)  fcnt2++;
  end

  task automatic drive(input logic lvl, input int unsigned n, input bit sel);
    if (sel) rxd2 = lvl;
    else     rxd  = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit sel);
    int unsigned n;
    n = sel ? CPB2 : CPB;
    drive(1'b0, n, sel);
    for (int i = 0; i < 8; i++) drive(b[i], n, sel);
    drive(stop, n, sel);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[8];
    int unsigned v0, f0, t_fall, k;
    logic [7:0]  cb;

    tbl[0] = '{8'h61, 8'h61};
    tbl[1] = '{8'h62, 8'h62};
    tbl[2] = '{8'h63, 8'h63};
    tbl[3] = '{8'h64, 8'h64};
    tbl[4] = '{8'h00, 8'h00};
    tbl[5] = '{8'hFF, 8'hFF};
    tbl[6] = '{8'h80, 8'h80};
    tbl[7] = '{8'h01, 8'h01};

    rst = 1'b1; rxd = 1'b1; rxd2 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_data",  32'(data),  0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_ferr",  32'(ferr),  0);
    chk("rst_busy",  32'(busy),  0);
    chk("rst_data5", 32'(data2), 0);
    chk("rst_busy5", 32'(busy2), 0);
    rst = 1'b0;
    drive(1'b1, 20, 1'b0);

    // Single byte; t_fall is the first edge that samples the low rxd.
    v0 = vcnt; f0 = fcnt; t_fall = cyc + 1;
    send_frame(8'h61, 1'b1, 1'b0);
    drive(1'b1, 20, 1'b0);
    chk("t1_valid_cnt", vcnt - v0, 1);
    chk("t1_data", 32'(data), 32'h61);
    chk("t1_ferr_cnt", fcnt - f0, 0);
    chk("t1_latency", vcyc - t_fall, 2 + 8 + 9 * 16);

    // Back-to-back frames with no idle gap.
    v0 = vcnt; f0 = fcnt;
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].tx, 1'b1, 1'b0);
      chk("b2b_valid_cnt", vcnt - v0, 32'(i + 1));
      chk("b2b_strobe_data", 32'(vdata), 32'(tbl[i].exp));
      chk("b2b_data", 32'(data), 32'(tbl[i].exp));
    end
    drive(1'b1, 20, 1'b0);
    chk("b2b_ferr_cnt", fcnt - f0, 0);

    // Glitch: 3 low cycles then high.
    v0 = vcnt; f0 = fcnt;
    drive(1'b0, 3, 1'b0);
    chk("glitch_busy_rise", 32'(busy), 1);
    rxd = 1'b1;
    k = 0;
    while (busy && k < CPB / 2 + 3) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("glitch_busy_fall", 32'(busy), 0);
    drive(1'b1, 200, 1'b0);
    chk("glitch_valid_cnt", vcnt - v0, 0);
    chk("glitch_ferr_cnt", fcnt - f0, 0);

    // Framing error: 0x55 with stop bit and 40 more cycles held low.
    v0 = vcnt; f0 = fcnt; t_fall = cyc + 1;
    send_frame(8'h55, 1'b0, 1'b0);
    drive(1'b0, 40, 1'b0);
    chk("fe_ferr_cnt", fcnt - f0, 1);
    chk("fe_latency", fcyc - t_fall, 2 + 8 + 9 * 16);
    chk("fe_valid_cnt", vcnt - v0, 0);
    chk("fe_data_held", 32'(data), 32'(tbl[7].exp));
    chk("fe_busy_while_low", 32'(busy), 1);
    drive(1'b1, CPB, 1'b0);
    chk("fe_busy_after_high", 32'(busy), 0);
    send_frame(8'h62, 1'b1, 1'b0);
    drive(1'b1, 20, 1'b0);
    chk("fe_next_valid_cnt", vcnt - v0, 1);
    chk("fe_next_ferr_cnt", fcnt - f0, 1);
    chk("fe_next_data", 32'(data), 32'h62);

    // Reset mid-frame during data bit 4 of 'c', then 'd'.
    v0 = vcnt; f0 = fcnt; cb = 8'h63;
    drive(1'b0, CPB, 1'b0);
    for (int i = 0; i < 4; i++) drive(cb[i], CPB, 1'b0);
    drive(cb[4], 8, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rxd = 1'b1;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_data", 32'(data), 0);
    drive(1'b1, 3 * CPB, 1'b0);
    chk("rst_mid_valid_cnt", vcnt - v0, 0);
    chk("rst_mid_ferr_cnt", fcnt - f0, 0);
    chk("rst_mid_data_idle", 32'(data), 0);
    send_frame(8'h64, 1'b1, 1'b0);
    drive(1'b1, 20, 1'b0);
    chk("rst_d_valid_cnt", vcnt - v0, 1);
    chk("rst_d_data", 32'(data), 32'h64);

    // Odd bit period on the CLKS_PER_BIT=5 instance.
    v0 = vcnt2; f0 = fcnt2; t_fall = cyc + 1;
    send_frame(8'hA5, 1'b1, 1'b1);
    drive(1'b1, 10, 1'b1);
    chk("odd_valid_cnt", vcnt2 - v0, 1);
    chk("odd_data", 32'(data2), 32'hA5);
    chk("odd_strobe_data", 32'(vdata2), 32'hA5);
    chk("odd_latency", vcyc2 - t_fall, 2 + 2 + 45);
    chk("odd_ferr_cnt", fcnt2 - f0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
